// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, 2-bit IR, 1-bit bypass, scan strobes.
// Optional feature: define TAP_INTSCAN_SE_EN to drive scan_se from Shift-DR under INTSCAN.
module tap_controller #(
    parameter logic [1:0] IR_RESET   = 2'b10,
    parameter logic [1:0] IR_CAPTURE = 2'b01
) (
    input  logic clock,
    input  logic reset,
    input  logic tms,
    input  logic tdi,
    output logic ir1,
    output logic ir2,
    output logic bypass_tdo,
    output logic ir_tdo,
    output logic ir_select,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic scan_se
);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    tap_state_t state_q, state_d;
    logic [1:0] ir_q, ir_d;
    logic [1:0] ir_sh_q, ir_sh_d;
    logic       bypass_q, bypass_d;

    // Next-state logic and Moore strobe decodes
    always_comb begin
        state_d    = state_q;
        ir_select  = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        case (state_q)
            TLR:      state_d = tms ? TLR    : RTI;
            RTI:      state_d = tms ? SEL_DR : RTI;
            SEL_DR:   state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: begin
                state_d    = tms ? EX1_DR : SH_DR;
                capture_dr = 1'b1;
            end
            SH_DR: begin
                state_d  = tms ? EX1_DR : SH_DR;
                shift_dr = 1'b1;
            end
            EX1_DR:   state_d = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: begin
                state_d   = tms ? SEL_DR : RTI;
                update_dr = 1'b1;
            end
            SEL_IR:   state_d = tms ? TLR    : CAP_IR;
            CAP_IR:   state_d = tms ? EX1_IR : SH_IR;
            SH_IR: begin
                state_d   = tms ? EX1_IR : SH_IR;
                ir_select = 1'b1;
            end
            EX1_IR: begin
                state_d   = tms ? UPD_IR : PAUSE_IR;
                ir_select = 1'b1;
            end
            PAUSE_IR: begin
                state_d   = tms ? EX2_IR : PAUSE_IR;
                ir_select = 1'b1;
            end
            EX2_IR: begin
                state_d   = tms ? UPD_IR : SH_IR;
                ir_select = 1'b1;
            end
            UPD_IR:   state_d = tms ? SEL_DR : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Register actions take effect on the edge that ends the named state
    always_comb begin
        ir_d     = ir_q;
        ir_sh_d  = ir_sh_q;
        bypass_d = bypass_q;
        case (state_q)
            TLR:    ir_d    = IR_RESET;
            CAP_IR: ir_sh_d = IR_CAPTURE;
            SH_IR:  ir_sh_d = {tdi, ir_sh_q[1]};
            UPD_IR: ir_d    = ir_sh_q;
            CAP_DR: bypass_d = 1'b0;
            SH_DR: begin
                if (ir_q == 2'b10) begin
                    bypass_d = tdi;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= TLR;
            ir_q     <= IR_RESET;
            ir_sh_q  <= 2'b00;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sh_q  <= ir_sh_d;
            bypass_q <= bypass_d;
        end
    end

    assign ir1        = ir_q[0];
    assign ir2        = ir_q[1];
    assign bypass_tdo = bypass_q;
    assign ir_tdo     = ir_sh_q[0];

`ifdef TAP_INTSCAN_SE_EN
    assign scan_se = shift_dr & (ir_q == 2'b11);
`else
    assign scan_se = 1'b0;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed scenarios plus random tms/tdi/reset
// against a table-driven reference model of the TAP.
module tb_tap_controller;

    logic clk = 1'b0;
    logic reset, tms, tdi;
    logic ir1, ir2, bypass_tdo, ir_tdo, ir_select;
    logic capture_dr, shift_dr, update_dr, scan_se;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    string m_state;
    int    m_ir, m_sh, m_byp;
    string nxt0[string];
    string nxt1[string];

    always #5 clk = ~clk;

    tap_controller dut (
        .clock      (clk),
        .reset      (reset),
        .tms        (tms),
        .tdi        (tdi),
        .ir1        (ir1),
        .ir2        (ir2),
        .bypass_tdo (bypass_tdo),
        .ir_tdo     (ir_tdo),
        .ir_select  (ir_select),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .scan_se    (scan_se)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic add_arc(input string s, input string on0, input string on1);
        nxt0[s] = on0;
        nxt1[s] = on1;
    endtask

    task automatic model_edge(input logic r, input logic t, input logic d);
        if (r) begin
            m_state = "TLR";
            m_ir    = 2;
            m_sh    = 0;
            m_byp   = 0;
        end else begin
            if (m_state == "TLR")   m_ir = 2;
            if (m_state == "CapIR") m_sh = 1;
            if (m_state == "ShIR")  m_sh = int'(d) * 2 + m_sh / 2;
            if (m_state == "UpdIR") m_ir = m_sh;
            if (m_state == "CapDR") m_byp = 0;
            if (m_state == "ShDR" && m_ir == 2) m_byp = int'(d);
            m_state = t ? nxt1[m_state] : nxt0[m_state];
        end
    endtask

    task automatic check_all();
        logic exp_se;
        logic exp_sel;
        exp_sel = (m_state == "ShIR" || m_state == "Ex1IR" ||
                   m_state == "PauseIR" || m_state == "Ex2IR");
`ifdef TAP_INTSCAN_SE_EN
        exp_se = (m_state == "ShDR") && (m_ir == 3);
`else
        exp_se = 1'b0;
`endif
        chk("ir",         {ir2, ir1},   2'(m_ir));
        chk("ir_tdo",     {1'b0, ir_tdo},     {1'b0, 1'(m_sh % 2)});
        chk("bypass_tdo", {1'b0, bypass_tdo}, {1'b0, 1'(m_byp)});
        chk("ir_select",  {1'b0, ir_select},  {1'b0, exp_sel});
        chk("capture_dr", {1'b0, capture_dr}, {1'b0, 1'(m_state == "CapDR")});
        chk("shift_dr",   {1'b0, shift_dr},   {1'b0, 1'(m_state == "ShDR")});
        chk("update_dr",  {1'b0, update_dr},  {1'b0, 1'(m_state == "UpdDR")});
        chk("scan_se",    {1'b0, scan_se},    {1'b0, exp_se});
    endtask

    task automatic step(input logic r, input logic t, input logic d);
        reset = r;
        tms   = t;
        tdi   = d;
        @(posedge clk);
        model_edge(r, t, d);
        #1;
        check_all();
    endtask

    // From RTI: walk to Shift-IR, shift b0 then b1, update, return to RTI
    task automatic load_ir(input logic b1, input logic b0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, b0);
        step(0, 1, b1);
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    initial begin
        add_arc("TLR",     "RTI",     "TLR");
        add_arc("RTI",     "RTI",     "SelDR");
        add_arc("SelDR",   "CapDR",   "SelIR");
        add_arc("SelIR",   "CapIR",   "TLR");
        add_arc("CapDR",   "ShDR",    "Ex1DR");
        add_arc("ShDR",    "ShDR",    "Ex1DR");
        add_arc("Ex1DR",   "PauseDR", "UpdDR");
        add_arc("PauseDR", "PauseDR", "Ex2DR");
        add_arc("Ex2DR",   "ShDR",    "UpdDR");
        add_arc("UpdDR",   "RTI",     "SelDR");
        add_arc("CapIR",   "ShIR",    "Ex1IR");
        add_arc("ShIR",    "ShIR",    "Ex1IR");
        add_arc("Ex1IR",   "PauseIR", "UpdIR");
        add_arc("PauseIR", "PauseIR", "Ex2IR");
        add_arc("Ex2IR",   "ShIR",    "UpdIR");
        add_arc("UpdIR",   "RTI",     "SelDR");
        m_state = "TLR";
        m_ir = 2; m_sh = 0; m_byp = 0;
        reset = 1'b1; tms = 1'b1; tdi = 1'b0;

        // Reset for one cycle
        step(1, 1, 0);
        chk("rst_ir", {ir2, ir1}, 2'b10);
        chk("rst_strobes", {1'b0, capture_dr | shift_dr | update_dr | ir_select | scan_se}, 2'b00);
        chk("rst_bypass", {1'b0, bypass_tdo}, 2'b00);

        // Load INTSCAN (11)
        step(0, 0, 0);
        load_ir(1, 1);
        chk("upd_ir_11", {ir2, ir1}, 2'b11);

        // Into Shift-DR with INTSCAN selected
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("shdr_shift", {1'b0, shift_dr}, 2'b01);
`ifdef TAP_INTSCAN_SE_EN
        chk("shdr_scan_se", {1'b0, scan_se}, 2'b01);
`else
        chk("shdr_scan_se", {1'b0, scan_se}, 2'b00);
`endif

        // Five tms=1 edges reach TLR; IR forced back on the edge ending TLR
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        step(0, 1, 0);
        chk("tlr_ir_forced", {ir2, ir1}, 2'b10);

        // Capture-IR then shift: ir_tdo shows 1 then 0; load BYPASS (10)
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("ir_tdo_first", {1'b0, ir_tdo}, 2'b01);
        step(0, 0, 0);
        chk("ir_tdo_second", {1'b0, ir_tdo}, 2'b00);
        step(0, 1, 1);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("ir_bypass", {ir2, ir1}, 2'b10);

        // Bypass shifting
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("byp_cap_clear", {1'b0, bypass_tdo}, 2'b00);
        step(0, 0, 1);
        chk("byp_shift1", {1'b0, bypass_tdo}, 2'b01);
        step(0, 0, 0);
        chk("byp_shift0", {1'b0, bypass_tdo}, 2'b00);
        step(0, 0, 1);
        chk("byp_shift1b", {1'b0, bypass_tdo}, 2'b01);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("byp_recapture", {1'b0, bypass_tdo}, 2'b00);

        // Reset in the middle of Shift-IR discards the partial shift
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        load_ir(1, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 1);
        chk("midshift_rst_ir", {ir2, ir1}, 2'b10);
        chk("midshift_rst_sel", {1'b0, ir_select}, 2'b00);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("midshift_no_upd", {ir2, ir1}, 2'b10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 59) == 0),
                 logic'($urandom_range(0, 9) < 4),
                 logic'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
